// File: rtl/vend_seq_ctrl_if.sv
// rtl/vend_seq_ctrl_if.sv - coin, cancel, acknowledge and status signals of the vending sequencer
interface vend_seq_ctrl_if;
   logic       i_nickle;
   logic       i_dime;
   logic       i_quarter;
   logic       i_cancel;
   logic       i_vend_ack;
   logic       i_pay_ack;
   logic       o_coin_en;
   logic [3:0] o_credit;
   logic       o_vend_req;
   logic       o_pay_req;
   logic       o_busy;
   logic       o_fault;

   modport slave (
      input  i_nickle, i_dime, i_quarter, i_cancel, i_vend_ack, i_pay_ack,
      output o_coin_en, o_credit, o_vend_req, o_pay_req, o_busy, o_fault
   );

   modport master (
      output i_nickle, i_dime, i_quarter, i_cancel, i_vend_ack, i_pay_ack,
      input  o_coin_en, o_credit, o_vend_req, o_pay_req, o_busy, o_fault
   );
endinterface

// File: rtl/vend_seq_ctrl.sv
// rtl/vend_seq_ctrl.sv - soda vending sequencer: coin collection, dispense handshake, nickel change return
module vend_seq_ctrl #(
   parameter int PRICE        = 4,
   parameter int VEND_TIMEOUT = 1000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   vend_seq_ctrl_if.slave   bus
);

   localparam int TW = (VEND_TIMEOUT > 1) ? $clog2(VEND_TIMEOUT) : 1;
   localparam logic [3:0]    W_PRICE   = 4'(PRICE);
   localparam logic [TW-1:0] W_TMO_END = TW'(VEND_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_VEND    = 3'd2,
      S_CHANGE  = 3'd3,
      S_FAULT   = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_credit;
   logic [3:0]      w_credit_nxt;
   logic [TW-1:0]   r_tmo;
   logic [TW-1:0]   w_tmo_nxt;
   logic [3:0]      w_coin;
   logic [3:0]      w_sum;

   // One coin per cycle; the cheaper coin wins when pulses collide.
   always_comb begin
      w_coin = 4'd0;
      if (bus.i_nickle)
         w_coin = 4'd1;
      else if (bus.i_dime)
         w_coin = 4'd2;
      else if (bus.i_quarter)
         w_coin = 4'd5;
   end

   // Credit never exceeds PRICE-1 while collecting, so the sum tops out at 12.
   assign w_sum = r_credit + w_coin;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_credit <= 4'd0;
         r_tmo    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_tmo    <= w_tmo_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_tmo_nxt    = r_tmo;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (w_sum >= W_PRICE) begin
               w_state_nxt  = S_VEND;
               w_credit_nxt = w_sum - W_PRICE;
               w_tmo_nxt    = '0;
            end else if (bus.i_cancel && (r_state == S_COLLECT)) begin
               w_state_nxt  = S_CHANGE;
               w_credit_nxt = w_sum;
            end else if (w_sum != 4'd0) begin
               w_state_nxt  = S_COLLECT;
               w_credit_nxt = w_sum;
            end else begin
               w_state_nxt  = S_IDLE;
            end
         end
         S_VEND: begin
            // An ack arriving in the last allowed cycle still completes the sale.
            if (bus.i_vend_ack) begin
               w_state_nxt = (r_credit != 4'd0) ? S_CHANGE : S_IDLE;
            end else if (r_tmo == W_TMO_END) begin
               w_state_nxt = S_FAULT;
            end else begin
               w_tmo_nxt = r_tmo + TW'(1);
            end
         end
         S_CHANGE: begin
            if (r_credit == 4'd0) begin
               w_state_nxt = S_IDLE;
            end else if (bus.i_pay_ack) begin
               w_credit_nxt = r_credit - 4'd1;
               if (r_credit == 4'd1)
                  w_state_nxt = S_IDLE;
            end
         end
         S_FAULT: begin
            w_state_nxt = S_FAULT;
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_credit_nxt = 4'd0;
            w_tmo_nxt    = '0;
         end
      endcase
   end

   assign bus.o_coin_en  = (r_state == S_IDLE) || (r_state == S_COLLECT);
   assign bus.o_credit   = r_credit;
   assign bus.o_vend_req = (r_state == S_VEND);
   assign bus.o_pay_req  = (r_state == S_CHANGE);
   assign bus.o_busy     = (r_state == S_VEND) || (r_state == S_CHANGE);
   assign bus.o_fault    = (r_state == S_FAULT);

endmodule

// File: doc/vend_seq_ctrl.md
VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

Interface
REQ-001 Parameter PRICE, default 4, soda price in nickel units (4 = 20 cents); legal range 1..8.
REQ-002 Parameter VEND_TIMEOUT, default 1000, max cycles in VEND awaiting i_vend_ack.
REQ-003 Port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port i_rst  input  1  synchronous active-high reset.
REQ-005 Ports i_nickle, i_dime, i_quarter  input  1 each  one-cycle coin pulses worth 1, 2, 5 nickels.
REQ-006 Port i_cancel  input  1  refund request, sampled each cycle.
REQ-007 Port i_vend_ack  input  1  dispenser done, one-cycle pulse.
REQ-008 Port i_pay_ack  input  1  change hopper ejected one nickel, one-cycle pulse.
REQ-009 Port o_coin_en  output  1  coin acceptor enable.
REQ-010 Port o_credit  output  4  current credit in nickels, registered.
REQ-011 Port o_vend_req  output  1  dispense request level.
REQ-012 Port o_pay_req  output  1  eject-one-nickel request level.
REQ-013 Port o_busy  output  1  high in VEND or CHANGE.
REQ-014 Port o_fault  output  1  high in FAULT.

Function
REQ-015 States SHALL be IDLE (credit 0), COLLECT (credit >0, <PRICE), VEND, CHANGE, FAULT; all outputs decode from registered state and credit only.
REQ-016 o_coin_en SHALL be high only in IDLE and COLLECT; coin pulses in any other state SHALL be ignored.
REQ-017 Simultaneous coin pulses: only one SHALL be counted, priority nickle > dime > quarter.
REQ-018 Coin at cycle N SHALL update o_credit at N+1; sum width 4 bits, max 12, no overflow possible.
REQ-019 If sum >= PRICE, next state SHALL be VEND with credit = sum - PRICE; o_vend_req high from N+1.
REQ-020 Else if sum >0, next state COLLECT with credit = sum.
REQ-021 i_cancel in COLLECT (no price reached) SHALL go to CHANGE with credit including any same-cycle coin; cancel in IDLE ignored; reaching PRICE overrides cancel.
REQ-022 VEND: o_vend_req held high until i_vend_ack; on ack cycle next state CHANGE if credit >0 else IDLE; o_vend_req low the cycle after ack.
REQ-023 VEND timeout counter SHALL clear on VEND entry, increment each VEND cycle; ack on the cycle count reaches VEND_TIMEOUT-1 SHALL be honored, otherwise next state FAULT.
REQ-024 FAULT: o_vend_req low, o_pay_req low, credit frozen, coins/cancel/acks ignored; exit only via reset.
REQ-025 CHANGE: o_pay_req held high; each i_pay_ack SHALL decrement credit by 1; ack with credit 1 SHALL go to IDLE with o_pay_req low next cycle.
REQ-026 i_vend_ack outside VEND and i_pay_ack outside CHANGE SHALL be ignored.
REQ-027 i_cancel outside IDLE/COLLECT SHALL be ignored.

Reset
REQ-028 i_rst high at a rising edge SHALL force IDLE, credit 0, timeout counter 0, o_vend_req 0, o_pay_req 0, o_busy 0, o_fault 0, o_coin_en 1 next cycle, from any state including mid-VEND, mid-CHANGE, and FAULT.
REQ-029 i_rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-030 PRICE=4: nickle, dime, dime pulses -> credit 1, 3, then VEND with credit 1; vend_ack -> CHANGE; one pay_ack -> IDLE, credit 0.
REQ-031 Quarter in IDLE -> VEND credit 1, o_coin_en 0; nickle during VEND ignored, credit stays 1.
REQ-032 Dime then cancel with nickle same cycle -> CHANGE credit 3; three pay_acks -> IDLE, o_pay_req low after third.
REQ-033 Nickle+dime+quarter same cycle in IDLE -> credit 1 only, state COLLECT.
REQ-034 VEND_TIMEOUT=8, no vend_ack -> FAULT after 8 VEND cycles, o_fault 1, credit retained; reset -> IDLE, all outputs at reset values.
REQ-035 Reset asserted mid-CHANGE with credit 4 -> IDLE, credit 0, o_pay_req 0 next cycle.
